// File: rtl/nco_burst_scheduler.sv
// Round-robin burst scheduler sharing one NCO select between NREQ requesters.
// Optional abort input/aborted output are enabled by defining NCO_SCHED_ABORT_EN.
//
// state | meaning
// IDLE  | arbitrating; req_ready shows the round-robin pick
// RUN   | driving the latched select, counting down the burst
// GAP   | guard cycles with IDLE_SEL before the next grant
module nco_burst_scheduler #(
    parameter int NREQ     = 4,
    parameter int SEL_W    = 3,
    parameter int CNT_W    = 8,
    parameter int GAP      = 2,
    parameter int IDLE_SEL = 0
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [NREQ-1:0]                req_valid,
    input  logic [NREQ*SEL_W-1:0]          req_sel,
    input  logic [NREQ*CNT_W-1:0]          req_len,
`ifdef NCO_SCHED_ABORT_EN
    input  logic                           abort,
    output logic                           aborted,
`endif
    output logic [NREQ-1:0]                req_ready,
    output logic [SEL_W-1:0]               signal_out,
    output logic [$clog2(NREQ)-1:0]        grant_id,
    output logic                           busy,
    output logic [NREQ-1:0]                done
);

    localparam int GID_W = $clog2(NREQ);
    localparam logic [SEL_W-1:0] IDLE_V = SEL_W'(IDLE_SEL);
    localparam logic [CNT_W-1:0] GAP_V  = CNT_W'(GAP);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   sig_q, sig_d;
    logic [GID_W-1:0]   gid_q, gid_d;
    logic [GID_W-1:0]   ptr_q, ptr_d;

    logic               pick_valid;
    logic [GID_W-1:0]   pick_idx;
    logic [SEL_W-1:0]   pick_sel;
    logic [CNT_W-1:0]   pick_len;
    logic               abort_hit;
    logic               last_sample;

`ifdef NCO_SCHED_ABORT_EN
    logic aborted_q, aborted_d;
    assign abort_hit = abort && (state_q != S_IDLE);
    assign aborted   = aborted_q;
`else
    assign abort_hit = 1'b0;
`endif

    // Two passes give the rotated search: indices at/after the pointer first, then wrap.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (!pick_valid && (j >= int'(ptr_q)) && req_valid[j]) begin
                pick_valid = 1'b1;
                pick_idx   = GID_W'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!pick_valid && (j < int'(ptr_q)) && req_valid[j]) begin
                pick_valid = 1'b1;
                pick_idx   = GID_W'(j);
            end
        end
    end

    always_comb begin
        pick_sel = '0;
        pick_len = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (pick_idx == GID_W'(j)) begin
                pick_sel = req_sel[j*SEL_W +: SEL_W];
                pick_len = req_len[j*CNT_W +: CNT_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sig_d   = sig_q;
        gid_d   = gid_q;
        ptr_d   = ptr_q;
`ifdef NCO_SCHED_ABORT_EN
        aborted_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    state_d = S_RUN;
                    gid_d   = pick_idx;
                    ptr_d   = (pick_idx == GID_W'(NREQ-1)) ? '0 : pick_idx + 1'b1;
                    sig_d   = pick_sel;
                    cnt_d   = (pick_len == '0) ? CNT_W'(1) : pick_len;
                end
            end
            S_RUN: begin
                if (cnt_q <= CNT_W'(1)) begin
                    sig_d = IDLE_V;
                    if (GAP == 0) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = GAP_V;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                sig_d   = IDLE_V;
                cnt_d   = '0;
            end
        endcase
        if (abort_hit) begin
            state_d = S_IDLE;
            sig_d   = IDLE_V;
            cnt_d   = '0;
`ifdef NCO_SCHED_ABORT_EN
            aborted_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sig_q   <= IDLE_V;
            gid_q   <= '0;
            ptr_q   <= '0;
`ifdef NCO_SCHED_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
            gid_q   <= gid_d;
            ptr_q   <= ptr_d;
`ifdef NCO_SCHED_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    // An abort landing on the final sample suppresses that burst's done pulse.
    assign last_sample = (state_q == S_RUN) && (cnt_q == CNT_W'(1)) && !abort_hit;

    always_comb begin
        req_ready = '0;
        done      = '0;
        for (int j = 0; j < NREQ; j++) begin
            req_ready[j] = (state_q == S_IDLE) && pick_valid && (pick_idx == GID_W'(j));
            done[j]      = last_sample && (gid_q == GID_W'(j));
        end
    end

    assign signal_out = sig_q;
    assign grant_id   = gid_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_nco_burst_scheduler.sv
// Directed testbench for nco_burst_scheduler with default parameters
// (NREQ=4, SEL_W=3, CNT_W=8, GAP=2, IDLE_SEL=0).
module tb_nco_burst_scheduler;

    logic        clk;
    logic        resetn;
    logic [3:0]  req_valid;
    logic [11:0] req_sel;
    logic [31:0] req_len;
    logic [3:0]  req_ready;
    logic [2:0]  signal_out;
    logic [1:0]  grant_id;
    logic        busy;
    logic [3:0]  done;
`ifdef NCO_SCHED_ABORT_EN
    logic        abort;
    logic        aborted;
`endif

    int errors = 0;
    int checks = 0;

    nco_burst_scheduler dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_sel    (req_sel),
        .req_len    (req_len),
`ifdef NCO_SCHED_ABORT_EN
        .abort      (abort),
        .aborted    (aborted),
`endif
        .req_ready  (req_ready),
        .signal_out (signal_out),
        .grant_id   (grant_id),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".sig"},  32'(signal_out), 32'd0);
        chk({tag, ".busy"}, 32'(busy),       32'd0);
        chk({tag, ".done"}, 32'(done),       32'd0);
    endtask

    initial begin
        resetn    = 1'b0;
        req_valid = 4'b0000;
        req_sel   = '0;
        req_len   = '0;
`ifdef NCO_SCHED_ABORT_EN
        abort     = 1'b0;
`endif

        // 1. reset held for 3 cycles
        tick(); tick(); tick();
        chk_idle("rst");
        chk("rst.ready", 32'(req_ready), 32'd0);
        chk("rst.gid",   32'(grant_id),  32'd0);

        // 2. single burst, sel=5 len=3
        resetn = 1'b1;
        tick();
        req_valid = 4'b0001;
        req_sel[2:0]  = 3'd5;
        req_len[7:0]  = 8'd3;
        #1;
        chk("b2.ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b0000;
        chk("b2.s1",    32'(signal_out), 32'd5);
        chk("b2.busy1", 32'(busy),       32'd1);
        chk("b2.done1", 32'(done),       32'd0);
        chk("b2.ready_run", 32'(req_ready), 32'd0);
        tick();
        chk("b2.s2",    32'(signal_out), 32'd5);
        chk("b2.done2", 32'(done),       32'd0);
        tick();
        chk("b2.s3",    32'(signal_out), 32'd5);
        chk("b2.done3", 32'(done),       32'b0001);
        tick();
        chk("b2.g1.sig",  32'(signal_out), 32'd0);
        chk("b2.g1.busy", 32'(busy),       32'd1);
        chk("b2.g1.done", 32'(done),       32'd0);
        tick();
        chk("b2.g2.sig",  32'(signal_out), 32'd0);
        chk("b2.g2.busy", 32'(busy),       32'd1);
        tick();
        chk_idle("b2.end");

        // 3. all valid, len=1, sel=i+1: fair order 0,1,2,3,0 with 3 idle-select cycles
        resetn    = 1'b0;
        req_valid = 4'b1111;
        req_sel   = {3'd4, 3'd3, 3'd2, 3'd1};
        req_len   = {8'd1, 8'd1, 8'd1, 8'd1};
        tick();
        resetn = 1'b1;
        for (int b = 0; b < 5; b++) begin
            int g;
            g = b % 4;
            #0;
            chk($sformatf("rr%0d.ready", b), 32'(req_ready), 32'(1 << g));
            chk($sformatf("rr%0d.idle", b),  32'(busy),      32'd0);
            tick();
            chk($sformatf("rr%0d.gid", b),  32'(grant_id),   32'(g));
            chk($sformatf("rr%0d.sig", b),  32'(signal_out), 32'(g + 1));
            chk($sformatf("rr%0d.done", b), 32'(done),       32'(1 << g));
            tick();
            chk($sformatf("rr%0d.gap1", b), 32'(signal_out), 32'd0);
            tick();
            chk($sformatf("rr%0d.gap2", b), 32'({busy, signal_out}), 32'h8);
            tick();
        end
        req_valid = 4'b0000;
        #1;
        chk_idle("rr.end");

        // 4. len=0 on requester 2 runs one sample
        req_valid = 4'b0100;
        req_sel[8:6]   = 3'd6;
        req_len[23:16] = 8'd0;
        #1;
        chk("z.ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'b0000;
        chk("z.sig",  32'(signal_out), 32'd6);
        chk("z.done", 32'(done),       32'b0100);
        chk("z.gid",  32'(grant_id),   32'd2);
        tick();
        chk("z.gap.sig",  32'(signal_out), 32'd0);
        chk("z.gap.done", 32'(done),       32'd0);
        tick();
        tick();
        chk_idle("z.end");

        // 5. reset during cycle 2 of a len=10 burst on requester 1
        req_valid = 4'b0010;
        req_sel[5:3]  = 3'd3;
        req_len[15:8] = 8'd10;
        tick();
        req_valid = 4'b0000;
        chk("mr.s1", 32'(signal_out), 32'd3);
        tick();
        chk("mr.s2", 32'(signal_out), 32'd3);
        resetn = 1'b0;
        tick();
        chk_idle("mr.rst");
        chk("mr.gid", 32'(grant_id), 32'd0);
        resetn = 1'b1;
        req_valid = 4'b1011;
        req_sel[2:0] = 3'd5;
        req_len[7:0] = 8'd1;
        #1;
        chk("mr.ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b0000;
        chk("mr.gid0", 32'(grant_id),   32'd0);
        chk("mr.sig0", 32'(signal_out), 32'd5);
        tick(); tick(); tick();
        chk_idle("mr.end");

`ifdef NCO_SCHED_ABORT_EN
        // 6. abort in cycle 4 of an 8-sample burst, then abort in IDLE, then on last sample
        req_valid = 4'b0001;
        req_sel[2:0] = 3'd7;
        req_len[7:0] = 8'd8;
        tick();
        req_valid = 4'b0000;
        tick(); tick(); tick();
        chk("ab.s4", 32'(signal_out), 32'd7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab.flag", 32'(aborted), 32'd1);
        chk_idle("ab.after");
        tick();
        chk("ab.flag_clr", 32'(aborted), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab.idle_flag", 32'(aborted), 32'd0);
        chk_idle("ab.idle");
        req_valid = 4'b0001;
        req_len[7:0] = 8'd2;
        tick();
        req_valid = 4'b0000;
        tick();
        abort = 1'b1;
        #1;
        chk("ab.last_done", 32'(done), 32'd0);
        tick();
        abort = 1'b0;
        chk("ab.last_flag", 32'(aborted), 32'd1);
        chk_idle("ab.last");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
